// File: rtl/xorshift_pkg.sv
// Shared definitions for the xorshift PRNG subordinate and its OBI fetcher:
// register word offsets, fetcher FSM states, and an address helper.
package xorshift_pkg;

  // Word offsets within the PRNG subordinate's register window
  localparam logic [1:0] REG_CTRL_OFFSET  = 2'h0;
  localparam logic [1:0] REG_RDATA_OFFSET = 2'h1;

  // Fetcher FSM: one sample is a CTRL write followed by an RDATA read
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TRIG_REQ = 3'd1,
    TRIG_RSP = 3'd2,
    READ_REQ = 3'd3,
    READ_RSP = 3'd4
  } fetch_state_e;

  // Byte offset of a register word inside the 16-byte aligned window
  function automatic logic [3:0] reg_byte_offset(input logic [1:0] word_off);
    return {word_off, 2'b00};
  endfunction

endpackage

// File: rtl/prn_obi_fetcher_fifo.sv
// Small first-word-fall-through FIFO holding fetched PRN words.
// Wrap-around pointers (DEPTH must be a power of two), occupancy counter.
// A push while full or a pop while empty is ignored.
module prn_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count_q;
  // Head word shown directly; forced to zero when nothing is stored
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are only meaningful behind the pointers
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/prn_obi_fetcher.sv
// OBI manager that keeps a local buffer of PRNG samples filled. Each sample
// is a write to the subordinate's CTRL register (advances the generator)
// followed by a read of RDATA; the read data is pushed into the FIFO.
//
// Handshakes:
//  - OBI request: req_o/we_o/addr_o/be_o/wdata_o/aid_o are held stable from
//    the first cycle req_o is high until the cycle gnt_i is sampled high;
//    the request is never withdrawn early. At most one transaction is
//    outstanding; its response is the next rvalid_i.
//  - PRN stream: a word transfers on every rising clock edge where
//    prn_valid_o & prn_ready_i; prn_data_o is valid whenever prn_valid_o.
module prn_obi_fetcher
  import xorshift_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned TXN_ID     = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  output logic                          req_o,
  output logic                          we_o,
  output logic [3:0]                    be_o,
  output logic [ADDR_WIDTH-1:0]         addr_o,
  output logic [DATA_WIDTH-1:0]         wdata_o,
  output logic [ID_WIDTH-1:0]           aid_o,
  input  logic                          gnt_i,
  input  logic                          rvalid_i,
  input  logic [DATA_WIDTH-1:0]         rdata_i,
  input  logic [ID_WIDTH-1:0]           rid_i,
  input  logic                          err_i,
  output logic                          prn_valid_o,
  input  logic                          prn_ready_i,
  output logic [DATA_WIDTH-1:0]         prn_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          err_o,
  input  logic                          clr_err_i,
  output fetch_state_e                  dbg_state_o
);

  localparam logic [ID_WIDTH-1:0] TXN_ID_W = ID_WIDTH'(TXN_ID);

  fetch_state_e state_q, state_d;
  logic         push;
  logic         set_err;
  logic         rsp_ok;
  logic         fifo_full;
  logic         fifo_empty;
  logic         err_q;
  logic [ADDR_WIDTH-5:0] base_hi;

  // Low nibble of the base is ignored: the register window is 16-byte aligned
  assign base_hi     = base_addr_i[ADDR_WIDTH-1:4];
  assign rsp_ok      = ~err_i & (rid_i == TXN_ID_W);
  assign wdata_o     = '0;
  assign aid_o       = TXN_ID_W;
  assign err_o       = err_q;
  assign prn_valid_o = ~fifo_empty;
  assign dbg_state_o = state_q;

  // State register, cleared asynchronously so a reset drops any transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a sample starts only in IDLE with a free FIFO slot, and
  // since nothing else pushes, that slot is still free when the read returns
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rvalid_i) set_err = 1'b1;
        if (enable_i && !fifo_full) state_d = TRIG_REQ;
      end
      TRIG_REQ: begin
        if (rvalid_i) set_err = 1'b1;
        if (gnt_i) state_d = TRIG_RSP;
      end
      TRIG_RSP: begin
        if (rvalid_i) begin
          if (rsp_ok) begin
            state_d = READ_REQ;
          end else begin
            set_err = 1'b1;
            state_d = IDLE;
          end
        end
      end
      READ_REQ: begin
        if (rvalid_i) set_err = 1'b1;
        if (gnt_i) state_d = READ_RSP;
      end
      READ_RSP: begin
        if (rvalid_i) begin
          if (rsp_ok) push    = 1'b1;
          else        set_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request outputs decoded from the registered state, so they stay stable
  // for the whole stall regardless of enable_i
  always_comb begin
    req_o  = 1'b0;
    we_o   = 1'b0;
    be_o   = 4'h0;
    addr_o = '0;
    if (state_q == TRIG_REQ) begin
      req_o  = 1'b1;
      we_o   = 1'b1;
      be_o   = 4'hF;
      addr_o = {base_hi, reg_byte_offset(REG_CTRL_OFFSET)};
    end else if (state_q == READ_REQ) begin
      req_o  = 1'b1;
      be_o   = 4'hF;
      addr_o = {base_hi, reg_byte_offset(REG_RDATA_OFFSET)};
    end
  end

  // Sticky error flag; a new error in the same cycle as a clear wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        err_q <= 1'b0;
    else if (set_err)   err_q <= 1'b1;
    else if (clr_err_i) err_q <= 1'b0;
  end

  prn_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (rdata_i),
    .pop_i   (prn_ready_i),
    .data_o  (prn_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fill_o)
  );

endmodule

// File: tb/tb_prn_obi_fetcher.sv
// Directed bench for prn_obi_fetcher with a behavioural OBI subordinate stub.
module tb_prn_obi_fetcher;
  import xorshift_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE_IN  = 32'h4000_100B;
  localparam logic [31:0] BASE_EXP = 32'h4000_1000;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  initial forever #5 clk_i = ~clk_i;

  logic        enable_i, prn_ready_i, clr_err_i;
  logic        req_o, we_o, gnt_i, rvalid_i, err_i, prn_valid_o, err_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o, rdata_i, prn_data_o;
  logic [0:0]  aid_o, rid_i;
  logic [2:0]  fill_o;
  fetch_state_e dbg_state;

  prn_obi_fetcher #(
    .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .TXN_ID(0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .base_addr_i(BASE_IN),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .aid_o(aid_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .rid_i(rid_i), .err_i(err_i), .prn_valid_o(prn_valid_o),
    .prn_ready_i(prn_ready_i), .prn_data_o(prn_data_o), .fill_o(fill_o),
    .err_o(err_o), .clr_err_i(clr_err_i), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // stub configuration and observations
  int          gnt_delay = 0;
  bit          err_on_read = 1'b0;
  bit          hold_rsp = 1'b0;
  bit          inject_rvalid = 1'b0;
  logic [31:0] rdata_val = 32'h1234_5678;
  int          n_wr = 0, n_rd = 0;
  int          stall_bad = 0, addr_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  function automatic bit probe(input int sel, input int val);
    case (sel)
      0:       return int'(fill_o) == val;
      1:       return int'(dbg_state) == val;
      2:       return int'(prn_valid_o) == val;
      default: return int'(err_o) == val;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int val, input int budget);
    int n = 0;
    while (!probe(sel, val) && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(probe(sel, val)), 64'd1);
  endtask

  task automatic count_req(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      cnt += int'(req_o);
    end
  endtask

  // Consumer: compare head against scoreboard, then pop one word
  task automatic pop_check(input string tag);
    check({tag, "_valid"}, 64'(prn_valid_o), 64'd1);
    check({tag, "_qsize"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) check({tag, "_data"}, 64'(prn_data_o), 64'(exp_q[0]));
    prn_ready_i = 1'b1;
    tick(1);
    prn_ready_i = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  // Subordinate stub: acts at each falling edge. Response for a grant given
  // in the previous cycle, then grant decision for the current request.
  task automatic stub_loop();
    int   wait_cnt = 0;
    logic gnt_we = 1'b0;
    logic [31:0] stall_addr = '0;
    logic stall_we = 1'b0;
    forever begin
      @(negedge clk_i);
      rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0; rid_i = '0;
      if (inject_rvalid) begin
        rvalid_i = 1'b1;
        inject_rvalid = 1'b0;
      end else if (gnt_i) begin
        if (gnt_we) n_wr++; else n_rd++;
        if (!hold_rsp) begin
          rvalid_i = 1'b1;
          if (!gnt_we) begin
            if (err_on_read) err_i = 1'b1;
            else begin
              rdata_i = rdata_val;
              exp_q.push_back(rdata_val);
              rdata_val = $urandom;
            end
          end
        end
      end
      gnt_i = 1'b0;
      if (req_o && rst_ni) begin
        if (wait_cnt == 0) begin
          stall_addr = addr_o;
          stall_we   = we_o;
        end else if (addr_o !== stall_addr || we_o !== stall_we) stall_bad++;
        if (addr_o !== (we_o ? BASE_EXP : BASE_EXP + 32'h4) || be_o !== 4'hF ||
            wdata_o !== '0 || aid_o !== '0) addr_bad++;
        if (wait_cnt >= gnt_delay) begin
          gnt_i    = 1'b1;
          gnt_we   = we_o;
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rq;
    int wr0, rd0;
    rst_ni = 1'b0; enable_i = 1'b0; prn_ready_i = 1'b0; clr_err_i = 1'b0;
    gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0; rid_i = '0;
    fork stub_loop(); join_none

    // reset values
    tick(2);
    check("rst_req", 64'(req_o), 64'd0);
    check("rst_we", 64'(we_o), 64'd0);
    check("rst_addr", 64'(addr_o), 64'd0);
    check("rst_valid", 64'(prn_valid_o), 64'd0);
    check("rst_fill", 64'(fill_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_ni = 1'b1;
    tick(1);

    // zero-wait latency: enable in c0, data visible in c5
    enable_i = 1'b1;
    tick(1);
    check("lat_c1_req", 64'(req_o), 64'd1);
    check("lat_c1_we", 64'(we_o), 64'd1);
    check("lat_c1_addr", 64'(addr_o), 64'(BASE_EXP));
    tick(2);
    check("lat_c3_we", 64'(we_o), 64'd0);
    check("lat_c3_addr", 64'(addr_o), 64'(BASE_EXP + 32'h4));
    tick(1);
    check("lat_c4_valid", 64'(prn_valid_o), 64'd0);
    tick(1);
    check("lat_c5_valid", 64'(prn_valid_o), 64'd1);
    check("lat_c5_data", 64'(prn_data_o), 64'h1234_5678);
    check("lat_c5_nwr", 64'(n_wr), 64'd1);
    check("lat_c5_nrd", 64'(n_rd), 64'd1);

    // saturation with consumer stalled
    wait_for("sat_fill4", 0, 4, 100);
    count_req(10, rq);
    check("sat_no_req", 64'(rq), 64'd0);
    check("sat_fill", 64'(fill_o), 64'd4);
    check("sat_nrd", 64'(n_rd), 64'd4);
    check("sat_qsize", 64'(exp_q.size()), 64'd4);
    pop_check("sat_pop");
    wait_for("sat_refill", 0, 4, 40);
    count_req(10, rq);
    check("sat_one_more", 64'(n_rd), 64'd5);
    check("sat_wr_eq_rd", 64'(n_wr), 64'd5);

    // drain with enable low
    enable_i = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) pop_check("drain");
    check("drain_fill", 64'(fill_o), 64'd0);
    check("drain_valid", 64'(prn_valid_o), 64'd0);
    check("drain_data0", 64'(prn_data_o), 64'd0);
    pop_check_empty: begin
      prn_ready_i = 1'b1;
      tick(1);
      prn_ready_i = 1'b0;
      check("pop_empty_fill", 64'(fill_o), 64'd0);
    end

    // grant delayed 3 cycles, single sample
    gnt_delay = 3; wr0 = n_wr; rd0 = n_rd;
    enable_i = 1'b1;
    tick(1);
    enable_i = 1'b0;
    wait_for("stall_valid", 2, 1, 40);
    check("stall_nwr", 64'(n_wr), 64'(wr0 + 1));
    check("stall_nrd", 64'(n_rd), 64'(rd0 + 1));
    check("stall_fill", 64'(fill_o), 64'd1);
    count_req(10, rq);
    check("stall_idle", 64'(rq), 64'd0);
    pop_check("stall_pop");

    // enable dropped while the read request is stalled
    wr0 = n_wr; rd0 = n_rd;
    enable_i = 1'b1;
    wait_for("drop_in_rdreq", 1, int'(READ_REQ), 40);
    enable_i = 1'b0;
    wait_for("drop_valid", 2, 1, 40);
    check("drop_nrd", 64'(n_rd), 64'(rd0 + 1));
    check("drop_fill", 64'(fill_o), 64'd1);
    count_req(10, rq);
    check("drop_no_req", 64'(rq), 64'd0);
    check("drop_nwr", 64'(n_wr), 64'(wr0 + 1));
    pop_check("drop_pop");

    // error on read response
    gnt_delay = 0; err_on_read = 1'b1;
    enable_i = 1'b1;
    wait_for("rderr_err", 3, 1, 40);
    check("rderr_fill", 64'(fill_o), 64'd0);
    check("rderr_state", 64'(dbg_state), 64'(IDLE));
    tick(1);
    check("rderr_restart", 64'(dbg_state), 64'(TRIG_REQ));
    enable_i = 1'b0; err_on_read = 1'b0;
    wait_for("rderr_recover", 2, 1, 40);
    check("rderr_sticky", 64'(err_o), 64'd1);
    pop_check("rderr_pop");
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    check("clr_err", 64'(err_o), 64'd0);

    // unexpected rvalid in IDLE colliding with a clear: the set wins
    inject_rvalid = 1'b1;
    tick(1);
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    check("set_beats_clr", 64'(err_o), 64'd1);
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    check("clr_err2", 64'(err_o), 64'd0);

    // asynchronous reset in the middle of a trigger response
    enable_i = 1'b1;
    wait_for("rstmid_fill1", 0, 1, 40);
    hold_rsp = 1'b1;
    wait_for("rstmid_trigrsp", 1, int'(TRIG_RSP), 20);
    enable_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("rstmid_req", 64'(req_o), 64'd0);
    check("rstmid_state", 64'(dbg_state), 64'(IDLE));
    check("rstmid_fill", 64'(fill_o), 64'd0);
    check("rstmid_valid", 64'(prn_valid_o), 64'd0);
    check("rstmid_data", 64'(prn_data_o), 64'd0);
    check("rstmid_addr", 64'(addr_o), 64'd0);
    exp_q.delete();
    tick(1);
    rst_ni = 1'b1;
    hold_rsp = 1'b0;
    inject_rvalid = 1'b1;
    tick(2);
    check("late_rvalid_err", 64'(err_o), 64'd1);
    check("late_rvalid_fill", 64'(fill_o), 64'd0);

    check("stall_stable", 64'(stall_bad), 64'd0);
    check("req_fields", 64'(addr_bad), 64'd0);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
